// File: rtl/branch_resolve.sv
// branch_resolve: ID/EX register plus Execute-stage resolution of branches, JAL and JALR,
// producing fetch redirect/flush and wrapping branch statistics.
module branch_resolve #(
    parameter int XLEN = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            FlushD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] LinkE,
    output logic            MisalignE,
    output logic [CNTW-1:0] BranchCnt,
    output logic [CNTW-1:0] TakenCnt
);
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc, r_pc4, r_rd1, r_rd2;
    logic            r_valid;
    logic [CNTW-1:0] r_bcnt, r_tcnt;

    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic            w_br, w_jal, w_jalr, w_cond, w_take;
    logic [XLEN-1:0] w_imm_b, w_imm_j, w_imm_i, w_jsum, w_target;

    assign w_op   = r_instr[6:0];
    assign w_f3   = r_instr[14:12];
    assign w_br   = (w_op == 7'b1100011) && (w_f3[2:1] != 2'b01);
    assign w_jal  = (w_op == 7'b1101111);
    assign w_jalr = (w_op == 7'b1100111) && (w_f3 == 3'b000);

    assign w_imm_b = {{(XLEN-12){r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
    assign w_imm_i = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};

    // funct3[2:1] picks eq / signed lt / unsigned lt; funct3[0] inverts the sense
    assign w_cond = ((w_f3[2:1] == 2'b00) ? (r_rd1 == r_rd2) :
                     w_f3[1] ? (r_rd1 < r_rd2) : ($signed(r_rd1) < $signed(r_rd2))) ^ w_f3[0];

    assign w_take   = r_valid & (w_jal | w_jalr | (w_br & w_cond));
    assign w_jsum   = r_rd1 + w_imm_i;
    assign w_target = w_jalr ? {w_jsum[XLEN-1:1], 1'b0} : r_pc + (w_jal ? w_imm_j : w_imm_b);

    assign PCSrcE    = w_take;
    assign PCTargetE = w_take ? w_target : r_pc4;
    assign FlushD    = w_take;
    assign MisalignE = w_take & PCTargetE[1];
    assign ValidE    = r_valid;
    assign RdE       = r_instr[11:7];
    assign RegWriteE = r_valid & (w_jal | w_jalr) & (RdE != 5'd0);
    assign LinkE     = r_pc4;
    assign BranchCnt = r_bcnt;
    assign TakenCnt  = r_tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_valid <= 1'b0;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
        end else begin
            r_instr <= w_take ? 32'd0 : InstrD;
            r_pc    <= w_take ? '0 : PCD;
            r_pc4   <= w_take ? '0 : PCPlus4D;
            r_rd1   <= w_take ? '0 : RD1D;
            r_rd2   <= w_take ? '0 : RD2D;
            r_valid <= ~w_take;
            if (r_valid & w_br) r_bcnt <= r_bcnt + CNTW'(1);
            if (w_take) r_tcnt <= r_tcnt + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vectors with a scoreboard queue; a negedge monitor checks each live Execute slot.
module tb_branch_resolve;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, RD1D = '0, RD2D = '0;
    logic        PCSrcE, FlushD, ValidE, RegWriteE, MisalignE;
    logic [31:0] PCTargetE, LinkE;
    logic [4:0]  RdE;
    logic [3:0]  BranchCnt, TakenCnt;

    branch_resolve #(.XLEN(32), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RD1D(RD1D), .RD2D(RD2D), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .FlushD(FlushD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .RdE(RdE), .LinkE(LinkE),
        .MisalignE(MisalignE), .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk, br, mis, rw;
        logic [31:0] tgt, link;
        logic [4:0]  rd;
        int          bc, tc;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    int m_b = 0, m_t = 0, exp_bub = 0, bubbles = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] eb(input logic [2:0] f3, input logic [12:0] im);
        return {im[12], im[10:5], 5'd0, 5'd0, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] ej(input logic [4:0] rd, input logic [20:0] im);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] ei(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] im);
        return {im, 5'd1, f3, rd, 7'b1100111};
    endfunction

    task automatic prep(input logic [31:0] ins, pc, a, b, input logic sq, br, tk,
                        input logic [31:0] tgt, input logic mis, rw, input logic [4:0] rd);
        exp_t e;
        InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; RD1D = a; RD2D = b;
        if (sq) exp_bub++;
        else begin
            e.tk = tk; e.br = br; e.mis = mis; e.rw = rw; e.tgt = tgt;
            e.link = pc + 32'd4; e.rd = rd; e.bc = m_b; e.tc = m_t;
            q.push_back(e);
            m_b += int'(br);
            m_t += int'(tk);
        end
    endtask

    task automatic issue(input logic [31:0] ins, pc, a, b, input logic sq, br, tk,
                         input logic [31:0] tgt, input logic mis, rw, input logic [4:0] rd);
        prep(ins, pc, a, b, sq, br, tk, tgt, mis, rw, rd);
        @(posedge clk); #1;
    endtask

    task automatic squash();
        issue(32'h13, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (ValidE) begin
                if (q.size() == 0) chk("unexpected_valid", 32'(ValidE), 32'd0);
                else begin
                    e = q.pop_front();
                    chk("PCSrcE", 32'(PCSrcE), 32'(e.tk));
                    chk("FlushD", 32'(FlushD), 32'(e.tk));
                    chk("PCTargetE", PCTargetE, e.tgt);
                    chk("MisalignE", 32'(MisalignE), 32'(e.mis));
                    chk("RegWriteE", 32'(RegWriteE), 32'(e.rw));
                    chk("LinkE", LinkE, e.link);
                    if (e.tk && !e.br) chk("RdE", 32'(RdE), 32'(e.rd));
                    chk("BranchCnt", 32'(BranchCnt), 32'(e.bc & 15));
                    chk("TakenCnt", 32'(TakenCnt), 32'(e.tc & 15));
                end
            end else bubbles++;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_PCSrcE"}, 32'(PCSrcE), 32'd0);
        chk({tag, "_ValidE"}, 32'(ValidE), 32'd0);
        chk({tag, "_PCTargetE"}, PCTargetE, 32'd0);
        chk({tag, "_FlushD"}, 32'(FlushD), 32'd0);
        chk({tag, "_RegWriteE"}, 32'(RegWriteE), 32'd0);
        chk({tag, "_MisalignE"}, 32'(MisalignE), 32'd0);
        chk({tag, "_LinkE"}, LinkE, 32'd0);
        chk({tag, "_RdE"}, 32'(RdE), 32'd0);
        chk({tag, "_BranchCnt"}, 32'(BranchCnt), 32'd0);
        chk({tag, "_TakenCnt"}, 32'(TakenCnt), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset("rst");
        @(negedge clk); #1 reset = 1'b0;
        // BEQ taken, then the D-stage instruction is squashed
        issue(eb(3'b000, 13'd16), 32'h100, 32'd5, 32'd5, 0, 1, 1, 32'h110, 0, 0, 5'd0);
        squash();
        issue(eb(3'b100, 13'h1FF8), 32'h200, 32'hFFFFFFFF, 32'd1, 0, 1, 1, 32'h1F8, 0, 0, 5'd0);
        squash();
        issue(eb(3'b110, 13'h20), 32'h300, 32'hFFFFFFFF, 32'd1, 0, 1, 0, 32'h304, 0, 0, 5'd0);
        issue(32'h13, 32'h304, 32'd0, 32'd0, 0, 0, 0, 32'h308, 0, 0, 5'd0);
        issue(ei(3'b000, 5'd1, 12'h0), 32'h40, 32'h203, 32'd0, 0, 0, 1, 32'h202, 1, 1, 5'd1);
        squash();
        issue(ej(5'd0, 21'd8), 32'hFFFFFFFC, 32'd0, 32'd0, 0, 0, 1, 32'h4, 0, 0, 5'd0);
        squash();
        issue(eb(3'b001, 13'h40), 32'h500, 32'd1, 32'd1, 0, 1, 0, 32'h504, 0, 0, 5'd0);
        issue(eb(3'b101, 13'h1F00), 32'h600, 32'd1, 32'hFFFFFFFF, 0, 1, 1, 32'h500, 0, 0, 5'd0);
        squash();
        issue(eb(3'b111, 13'h40), 32'h700, 32'd1, 32'hFFFFFFFF, 0, 1, 0, 32'h704, 0, 0, 5'd0);
        issue(eb(3'b010, 13'h40), 32'h800, 32'd1, 32'd1, 0, 0, 0, 32'h804, 0, 0, 5'd0);
        issue(ei(3'b001, 5'd3, 12'h10), 32'h900, 32'h40, 32'd0, 0, 0, 0, 32'h904, 0, 0, 5'd0);
        issue(ei(3'b000, 5'd5, 12'hFFC), 32'hA00, 32'h1000, 32'd0, 0, 0, 1, 32'hFFC, 0, 1, 5'd5);
        squash();
        // back-to-back: not-taken branch followed by JAL resolving the next cycle
        issue(eb(3'b000, 13'd8), 32'hB00, 32'd1, 32'd2, 0, 1, 0, 32'hB04, 0, 0, 5'd0);
        issue(ej(5'd1, 21'h100), 32'hB04, 32'd0, 32'd0, 0, 0, 1, 32'hC04, 0, 1, 5'd1);
        squash();
        // drive both counters through their 4-bit wrap
        for (int i = 0; i < 9; i++) begin
            issue(eb(3'b000, 13'd16), 32'h1000 + 32'(i) * 32'h20, 32'd7, 32'd7, 0, 1, 1,
                  32'h1010 + 32'(i) * 32'h20, 0, 0, 5'd0);
            squash();
        end
        issue(32'h13, 32'h2000, 32'd0, 32'd0, 0, 0, 0, 32'h2004, 0, 0, 5'd0);
        issue(ej(5'd1, 21'h10), 32'hD00, 32'd0, 32'd0, 0, 0, 1, 32'hD10, 0, 1, 5'd1);
        // reset while a taken JAL sits in Execute
        @(negedge clk); #2;
        InstrD = ej(5'd2, 21'h40); PCD = 32'hD04; PCPlus4D = 32'hD08;
        reset = 1'b1;
        #1 chk_reset("midrst");
        m_b = 0; m_t = 0;
        @(negedge clk); #1;
        prep(eb(3'b000, 13'd8), 32'hE00, 32'd1, 32'd2, 0, 1, 0, 32'hE04, 0, 0, 5'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #2 reset = 1'b1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("bubbles", 32'(bubbles), 32'(exp_bub));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
